store_write_buffer: RTL
=======================

Name: store_write_buffer

Overview:
- FIFO write buffer between the EX/MEM pipeline register and the data memory.
- Accepts committed stores (sw/sh/sb) from the MEM stage and queues them.
- Drains one store per cycle into the data memory write port whenever the port is free.
- Flags loads whose word address matches a pending store, so the hazard unit stalls until that store has drained.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of 2, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- St_Valid  input  1  store request from the MEM stage this cycle.
- St_Address  input  32  store byte address.
- St_Data  input  32  store data (byte/half stores use the low bits).
- St_Size  input  2  store type: 01 sw, 10 sb, 11 sh, 00 none.
- St_Ready  output  1  buffer can accept a store this cycle.
- Ld_Address  input  32  load byte address presented in the MEM stage.
- Ld_Size  input  2  load type: 01 lw, 10 lb, 11 lh, 00 none.
- Ld_Conflict  output  1  a pending store targets the same word as the load.
- Drain_Enable  input  1  data memory write port is free this cycle.
- Mem_Address  output  32  address to data memory write port.
- Mem_WriteData  output  32  data to data memory write port.
- Mem_MemWrite  output  2  write control to data memory, same encoding as St_Size; 00 means idle.
- Count  output  PTR_W+1  number of valid entries.

Behaviour:
- Storage:
  - DEPTH entries, each holding {address[31:0], data[31:0], size[1:0]}.
  - Head pointer (rd_ptr) and tail pointer (wr_ptr), each PTR_W bits, wrap modulo DEPTH.
  - Registered Count tracks the number of valid entries.
- Reset (asynchronous, takes effect immediately on Reset high):
  - rd_ptr = wr_ptr = 0 and Count = 0.
  - Pending stores are discarded; entry contents are don't-care.
  - Outputs during and after reset: St_Ready=1, Ld_Conflict=0, Mem_MemWrite=00, Mem_Address=0, Mem_WriteData=0.
  - Reset mid-drain suppresses that cycle's write (Mem_MemWrite forced to 00).
- St_Ready: combinational, St_Ready = (Count != DEPTH). There is no full-bypass: when full, St_Ready=0 even if a drain occurs in the same cycle.
- Push:
  - Occurs on a rising edge when St_Valid=1, St_Ready=1 and St_Size!=00.
  - Writes the entry at wr_ptr, then wr_ptr+1.
  - St_Valid with St_Size=00 is ignored.
  - A push attempted while full is dropped; the hazard unit must not issue it.
- Drain (pop):
  - drain = (Count!=0) && Drain_Enable && !Reset.
  - While drain=1: Mem_Address, Mem_WriteData and Mem_MemWrite come combinationally from the head entry. The memory captures the write on the same rising edge, and rd_ptr advances.
  - While drain=0: Mem_MemWrite=00, and Mem_Address/Mem_WriteData hold the head entry's values (or 0 when empty).
- Count update:
  - push only: +1.
  - drain only: -1.
  - both: unchanged.
  - neither: unchanged.
- Latency and ordering:
  - A store pushed at edge N is drained at edge N+1 at the earliest. There is no same-cycle pass-through.
  - Stores drain strictly in program (FIFO) order.
- Ld_Conflict:
  - Combinational. Equals 1 iff Ld_Size!=00 and any valid entry has address[16:2] == Ld_Address[16:2].
  - Comparison is at word granularity, ignoring byte offset and size.
  - The head entry counts as valid during its drain cycle.
  - A store being pushed in the same cycle is not compared, because loads and stores are mutually exclusive in the MEM stage.
  - The hazard unit holds the load until Ld_Conflict=0.
- Wrap-around: pointer wrap from DEPTH-1 to 0 is transparent; validity derives from Count and the pointers, never from stale entry contents.
- Simultaneous push+drain at Count=DEPTH-1: Count stays at DEPTH-1 and St_Ready stays 1.

Test Plan:
- Reset then one sw: push St_Address=0x10, St_Data=0xDEADBEEF, St_Size=01, Drain_Enable=0 -> Count=1, Mem_MemWrite=00. Next cycle raise Drain_Enable -> Mem_Address=0x10, Mem_WriteData=0xDEADBEEF, Mem_MemWrite=01 for one cycle, then Count=0.
- Fill with Drain_Enable=0: 4 stores to 0x0,0x4,0x8,0xC -> Count=4, St_Ready=0; a 5th St_Valid is ignored. Enable drain -> writes to 0x0,0x4,0x8,0xC in order over 4 cycles, then St_Ready=1.
- Push+drain same cycle with Count=2 for 6 cycles (pointer wrap) -> Count stays 2 and drain order matches push order exactly.
- Conflict: pending sb to 0x23, load lw at 0x20 -> Ld_Conflict=1. Load at 0x24 -> 0. After the sb drains -> load at 0x20 gives 0. Ld_Size=00 -> always 0.
- Mixed sizes: sh to 0x40 with 0x0000ABCD, then sb to 0x44 with 0x00000077 -> Mem_MemWrite sequence 11 then 10, with data passed unmodified.
- Reset asserted asynchronously mid-drain with Count=3 -> Mem_MemWrite=00 immediately, Count=0, St_Ready=1, no further writes after release.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// Bus bundle for the store write buffer: store push port, load-conflict
// probe, data-memory write port and occupancy count.
interface store_write_buffer_if #(
  parameter int PTR_W = 2
);
  logic             St_Valid;
  logic [31:0]      St_Address;
  logic [31:0]      St_Data;
  logic [1:0]       St_Size;
  logic             St_Ready;
  logic [31:0]      Ld_Address;
  logic [1:0]       Ld_Size;
  logic             Ld_Conflict;
  logic             Drain_Enable;
  logic [31:0]      Mem_Address;
  logic [31:0]      Mem_WriteData;
  logic [1:0]       Mem_MemWrite;
  logic [PTR_W:0]   Count;

  // MEM stage / hazard unit / memory side
  modport master (
    output St_Valid, St_Address, St_Data, St_Size, Ld_Address, Ld_Size, Drain_Enable,
    input  St_Ready, Ld_Conflict, Mem_Address, Mem_WriteData, Mem_MemWrite, Count
  );

  // Buffer side
  modport slave (
    input  St_Valid, St_Address, St_Data, St_Size, Ld_Address, Ld_Size, Drain_Enable,
    output St_Ready, Ld_Conflict, Mem_Address, Mem_WriteData, Mem_MemWrite, Count
  );
endinterface

// File: rtl/store_write_buffer.sv
// FIFO store write buffer between EX/MEM and the data memory. Queues committed
// stores, drains one per cycle when the memory write port is free, and flags
// loads that hit the same word as any pending store.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic                Clk,
  input logic                Reset,
  store_write_buffer_if.slave bus
);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } entry_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  entry_t entry_q [DEPTH];
  ptr_t   rd_ptr_q, rd_ptr_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  cnt_t   count_q, count_d;

  logic   not_full;
  logic   push;
  logic   drain;
  logic   ld_conflict;
  ptr_t   slot_off;
  entry_t head;
  logic   unused_ld_bits;

  // No full-bypass: a full buffer refuses stores even if it drains this cycle.
  assign not_full = (count_q != CNT_FULL);
  assign push     = bus.St_Valid && not_full && (bus.St_Size != 2'b00);
  assign drain    = (count_q != '0) && bus.Drain_Enable && !Reset;
  assign head     = entry_q[rd_ptr_q];

  // Only the word index of the load address takes part in the match.
  assign unused_ld_bits = &{1'b0, bus.Ld_Address[31:17], bus.Ld_Address[1:0]};

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (drain) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !drain)      count_d = count_q + CNT_ONE;
    else if (drain && !push) count_d = count_q - CNT_ONE;
  end

  // Control state register; reset drops every pending store.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the tail on each accepted push.
  // NOTE: storage is not reset; validity comes only from count and pointers, so stale contents are harmless.
  always_ff @(posedge Clk) begin
    if (push) entry_q[wr_ptr_q] <= {bus.St_Address, bus.St_Data, bus.St_Size};
  end

  // Memory write port driven straight from the head entry.
  always_comb begin
    bus.Mem_Address   = '0;
    bus.Mem_WriteData = '0;
    bus.Mem_MemWrite  = 2'b00;
    if (count_q != '0) begin
      bus.Mem_Address   = head.addr;
      bus.Mem_WriteData = head.data;
    end
    if (drain) bus.Mem_MemWrite = head.size;
  end

  // Word-granular match of the load against every occupied slot.
  always_comb begin
    ld_conflict = 1'b0;
    slot_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = ptr_t'(i) - rd_ptr_q;
      if ((cnt_t'(slot_off) < count_q) &&
          (entry_q[i].addr[16:2] == bus.Ld_Address[16:2]))
        ld_conflict = 1'b1;
    end
    if (bus.Ld_Size == 2'b00) ld_conflict = 1'b0;
  end

  assign bus.St_Ready    = not_full;
  assign bus.Ld_Conflict = ld_conflict;
  assign bus.Count       = count_q;

endmodule
